// File: rtl/usb_serial_tx.sv
// Full-speed USB transmit serializer: SYNC, LSB-first data with bit
// stuffing and NRZI coding, then EOP, driven onto the dp/dm pair.
module usb_serial_tx #(
    parameter int BIT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       dp,
    output logic       dm,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        EOP
    } state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [3:0]    idx;
    logic [7:0]    shreg;
    logic          last_q;
    logic [2:0]    ones_cnt;
    logic          lvl;

    logic tick;
    logic stuff;
    logic load_pt;
    logic raw;
    logic nrzi;

    assign tick  = (bit_cnt == LAST_CNT);
    assign stuff = (state == DATA) && (ones_cnt == 3'd6);

    // idx holds the SYNC bit on the line, or the count of data bits sent
    assign load_pt = tick &&
                     ((state == SYNC && idx == 4'd7) ||
                      (state == DATA && !stuff && idx == 4'd8 && !last_q));

    assign byte_ready = load_pt && byte_valid;
    assign underrun   = load_pt && !byte_valid;
    assign done       = (state == EOP) && (idx == 4'd2) && tick;
    assign busy       = (state != IDLE);

    always_comb begin
        raw = 1'b0;
        if (load_pt) begin
            raw = byte_in[0];
        end else if (state == SYNC) begin
            raw = (idx == 4'd6);
        end else if (state == DATA && !stuff) begin
            raw = shreg[idx[2:0]];
        end
        nrzi = raw ? lvl : ~lvl;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            idx      <= '0;
            shreg    <= '0;
            last_q   <= 1'b0;
            ones_cnt <= '0;
            lvl      <= 1'b1;
            dp       <= 1'b1;
            dm       <= 1'b0;
        end else begin
            bit_cnt <= (state == IDLE || tick) ? '0 : bit_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    if (byte_valid) begin
                        state    <= SYNC;
                        idx      <= '0;
                        ones_cnt <= '0;
                        lvl      <= 1'b0;
                        dp       <= 1'b0;
                        dm       <= 1'b1;
                    end
                end
                SYNC, DATA: begin
                    if (tick) begin
                        if (load_pt) begin
                            if (byte_valid) begin
                                state    <= DATA;
                                shreg    <= byte_in;
                                last_q   <= byte_last;
                                idx      <= 4'd1;
                                ones_cnt <= raw ? ones_cnt + 3'd1 : 3'd0;
                                lvl      <= nrzi;
                                dp       <= nrzi;
                                dm       <= ~nrzi;
                            end else begin
                                state <= EOP;
                                idx   <= '0;
                                dp    <= 1'b0;
                                dm    <= 1'b0;
                            end
                        end else if (state == DATA && idx == 4'd8 && !stuff) begin
                            state <= EOP;
                            idx   <= '0;
                            dp    <= 1'b0;
                            dm    <= 1'b0;
                        end else begin
                            // a stuffed zero leaves the shifter position alone
                            if (!stuff) begin
                                idx <= idx + 4'd1;
                            end
                            ones_cnt <= raw ? ones_cnt + 3'd1 : 3'd0;
                            lvl      <= nrzi;
                            dp       <= nrzi;
                            dm       <= ~nrzi;
                        end
                    end
                end
                EOP: begin
                    if (tick) begin
                        if (idx == 4'd2) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                            dp  <= (idx == 4'd1);
                            dm  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_serial_tx.sv
// Randomized bench for usb_serial_tx: a bit-stream model predicts every
// cycle's line levels and handshake pulses, one process compares them.
module tb_usb_serial_tx;

    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic       byte_last = 1'b0;
    logic       byte_ready;
    logic       dp;
    logic       dm;
    logic       busy;
    logic       done;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic dp;
        logic dm;
        logic busy;
        logic done;
        logic rdy;
        logic ur;
    } rec_t;

    rec_t expq[$];
    rec_t cur;

    logic [7:0] pkt[$];
    int         uk = -1;
    logic [1:0] sym[$];
    int         ldc[$];
    int         urc;
    int         nbt;
    int         nstuff;

    usb_serial_tx #(.BIT_CYCLES(BC)) dut (
        .clock      (clk),
        .reset      (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .dp         (dp),
        .dm         (dm),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic a, input logic b, input logic c,
                                input logic d, input logic e, input logic f);
        rec_t t;
        t.dp   = a;
        t.dm   = b;
        t.busy = c;
        t.done = d;
        t.rdy  = e;
        t.ur   = f;
        return t;
    endfunction

    // Raw bit stream -> stuffed stream -> NRZI line symbols, plus the
    // cycle of each load point (packet start is cycle 0).
    task automatic build_model();
        logic raw[$];
        int   ones;
        logic lv;
        logic v;
        sym.delete();
        ldc.delete();
        raw.delete();
        urc    = -1;
        nstuff = 0;
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        ones = 1;
        for (int j = 0; j < pkt.size(); j++) begin
            if (j == uk) begin
                urc = raw.size() * BC;
                break;
            end
            ldc.push_back(raw.size() * BC);
            for (int b = 0; b < 8; b++) begin
                v = pkt[j][b];
                raw.push_back(v);
                ones = v ? ones + 1 : 0;
                if (ones == 6) begin
                    raw.push_back(1'b0);
                    ones = 0;
                    nstuff++;
                end
            end
        end
        lv = 1'b1;
        foreach (raw[k]) begin
            if (!raw[k]) lv = !lv;
            sym.push_back({lv, !lv});
        end
        sym.push_back(2'b00);
        sym.push_back(2'b00);
        sym.push_back(2'b10);
        nbt = sym.size();
    endtask

    task automatic run_pkt(input int rst_at);
        rec_t       r;
        logic [1:0] s;
        int         j;
        int         last_c;
        last_c = nbt * BC;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk);
            #1;
            j = -1;
            foreach (ldc[k]) if (ldc[k] == c) j = k;
            rst        = (c == rst_at);
            byte_in    = 8'($urandom);
            byte_last  = 1'($urandom);
            if (j >= 0) begin
                byte_valid = 1'b1;
                byte_in    = pkt[j];
                byte_last  = (j == pkt.size() - 1);
            end else if (c == urc || c == 0) begin
                byte_valid = (c == 0);
            end else begin
                byte_valid = 1'($urandom);
            end
            if (c == 0) begin
                r = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end else begin
                s = sym[(c - 1) / BC];
                r = mk(s[1], s[0], 1'b1, c == last_c, j >= 0, c == urc);
            end
            expq.push_back(r);
            if (c == rst_at) break;
        end
        repeat (rst_at >= 0 ? 2 : $urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
            rst        = 1'b0;
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            cur = expq.pop_front();
            chk("dp", dp, cur.dp);
            chk("dm", dm, cur.dm);
            chk("busy", busy, cur.busy);
            chk("done", done, cur.done);
            chk("byte_ready", byte_ready, cur.rdy);
            chk("underrun", underrun, cur.ur);
        end
    end

    initial begin
        int len;
        repeat (3) begin
            @(posedge clk);
            #1;
            expq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end

        pkt = '{8'h00};
        uk  = -1;
        build_model();
        chk("m00_bits", nbt, 19);
        chk("m00_sync0", sym[0], 2'b01);
        chk("m00_sync7", sym[7], 2'b01);
        chk("m00_data0", sym[8], 2'b10);
        chk("m00_data7", sym[15], 2'b01);
        run_pkt(-1);

        pkt = '{8'hFF};
        build_model();
        chk("mff_bits", nbt, 20);
        chk("mff_stuffs", nstuff, 1);
        chk("mff_stuffsym", sym[13], 2'b10);
        run_pkt(-1);

        pkt = '{8'hA5, 8'h3C};
        build_model();
        chk("ma5_load0", ldc[0], 8 * BC);
        chk("ma5_load1", ldc[1], 16 * BC);
        chk("ma5_done", nbt * BC, 27 * BC);
        run_pkt(-1);

        pkt = '{8'h12, 8'h34};
        uk  = 1;
        build_model();
        chk("mur_cycle", urc, 16 * BC);
        chk("mur_bits", nbt, 19);
        run_pkt(-1);
        uk = -1;

        pkt = '{8'h5A, 8'hC3};
        build_model();
        run_pkt(11 * BC + 1 + int'($urandom_range(0, BC - 1)));

        pkt = '{8'h00};
        build_model();
        run_pkt(-1);

        pkt = '{8'h80, 8'h1F};
        build_model();
        chk("m80_stuffs", nstuff, 1);
        chk("m80_bits", nbt, 28);
        chk("m80_load1", ldc[1], 16 * BC);
        run_pkt(-1);

        for (int p = 0; p < 25; p++) begin
            len = $urandom_range(1, 4);
            pkt.delete();
            for (int i = 0; i < len; i++)
                pkt.push_back(($urandom % 3 == 0) ? 8'hFF : 8'($urandom));
            uk = ($urandom % 5 == 0) ? int'($urandom_range(0, len - 1)) : -1;
            build_model();
            run_pkt(-1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
